// File: rtl/btn_mode_ctrl.sv
// btn_mode_ctrl: debounces four raw buttons, classifies short/long L presses
// and runs the watch / stopwatch / time-set mode FSM with registered outputs.
// Ports: clk, rst (async active-low), btnL/btnR/btnU/btnD raw inputs;
//        sel (0 watch, 1 stopwatch), set_mode, wt_field (0 none, 1 h, 2 m, 3 s),
//        wt_up/wt_down, sw_runstop/sw_clear one-cycle command pulses.
// Build option: AUTO_REPEAT_EN adds U/D auto-repeat while held in SET states.
module btn_mode_ctrl #(
    parameter int DB_CYC   = 1_000_000,
    parameter int LONG_CYC = 100_000_000,
    parameter int RPT_CYC  = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnU,
    input  logic       btnD,
    output logic       sel,
    output logic       set_mode,
    output logic [1:0] wt_field,
    output logic       wt_up,
    output logic       wt_down,
    output logic       sw_runstop,
    output logic       sw_clear
);

    localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int HW  = $clog2(LONG_CYC + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
    localparam logic [HW-1:0]  H_LONG  = HW'(LONG_CYC);

    typedef enum logic [2:0] {
        S_WATCH, S_SW, S_HOUR, S_MIN, S_SEC
    } state_t;

    // bit order: 0 = L, 1 = R, 2 = U, 3 = D
    logic [3:0]     w_raw;
    logic [3:0]     r_sy1, r_sy2, r_deb, r_deb_d;
    logic [DBW-1:0] r_dbc [4];
    logic [3:0]     w_rise, w_fall;

    assign w_raw  = {btnD, btnU, btnR, btnL};
    assign w_rise = r_deb & ~r_deb_d;
    assign w_fall = ~r_deb & r_deb_d;

    // Any sample equal to the current debounced level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sy1   <= '0;
            r_sy2   <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 4; i++) r_dbc[i] <= '0;
        end else begin
            r_sy1   <= w_raw;
            r_sy2   <= r_sy1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_sy2[i] == r_deb[i]) begin
                    r_dbc[i] <= '0;
                end else if (r_dbc[i] == DB_LAST) begin
                    r_deb[i] <= r_sy2[i];
                    r_dbc[i] <= '0;
                end else begin
                    r_dbc[i] <= r_dbc[i] + DBW'(1);
                end
            end
        end
    end

    // L hold counter; r_at_l remembers that the long event already fired.
    logic [HW-1:0] r_hold_l;
    logic          r_at_l;
    logic          w_at_l, w_l_long, w_l_short, w_l_any;

    assign w_at_l    = r_deb[0] && (r_hold_l == H_LONG);
    assign w_l_long  = w_at_l && !r_at_l;
    assign w_l_short = w_fall[0] && !r_at_l;
    assign w_l_any   = w_l_long || w_l_short;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_l <= '0;
            r_at_l   <= 1'b0;
        end else begin
            r_at_l <= w_at_l;
            if (!r_deb[0])
                r_hold_l <= '0;
            else if (r_hold_l != H_LONG)
                r_hold_l <= r_hold_l + HW'(1);
        end
    end

    // U/D repeat events, index 0 = U, 1 = D.
    logic [1:0] w_rep;
`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(RPT_CYC + 1);
    localparam logic [RW-1:0] R_PER = RW'(RPT_CYC);

    logic [HW-1:0] r_hold_ud [2];
    logic [RW-1:0] r_rpt [2];
    logic [1:0]    r_at_ud;
    logic [1:0]    w_at_ud;

    always_comb begin
        w_at_ud = '0;
        w_rep   = '0;
        for (int j = 0; j < 2; j++) begin
            w_at_ud[j] = r_deb[2+j] && (r_hold_ud[j] == H_LONG);
            w_rep[j]   = (w_at_ud[j] && !r_at_ud[j])
                      || (r_deb[2+j] && (r_rpt[j] == R_PER));
        end
    end

    // r_rpt counts cycles since the last repeat; 0 means not started.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_at_ud <= '0;
            for (int j = 0; j < 2; j++) begin
                r_hold_ud[j] <= '0;
                r_rpt[j]     <= '0;
            end
        end else begin
            r_at_ud <= w_at_ud;
            for (int j = 0; j < 2; j++) begin
                if (!r_deb[2+j]) begin
                    r_hold_ud[j] <= '0;
                    r_rpt[j]     <= '0;
                end else begin
                    if (r_hold_ud[j] != H_LONG)
                        r_hold_ud[j] <= r_hold_ud[j] + HW'(1);
                    if (w_rep[j])
                        r_rpt[j] <= RW'(1);
                    else if (r_rpt[j] != '0)
                        r_rpt[j] <= r_rpt[j] + RW'(1);
                end
            end
        end
    end
`else
    assign w_rep = 2'b00;
`endif

    state_t     r_state, w_next;
    logic       w_chg, w_in_set;
    logic [1:0] r_blk;
    logic [1:0] w_ud_ev;
    logic       w_r_ev, w_u_ev, w_d_ev;

    assign w_chg    = (w_next != r_state);
    assign w_in_set = (r_state == S_HOUR) || (r_state == S_MIN)
                   || (r_state == S_SEC);

    // Held U/D across a mode change stay muted until released;
    // U+D together mute both.
    assign w_ud_ev = (w_rise[3:2] | w_rep) & ~r_blk
                   & {2{~&r_deb[3:2]}};
    assign w_r_ev  = w_rise[1] && !w_l_any;
    assign w_u_ev  = w_ud_ev[0] && !w_l_any && !w_rise[1];
    assign w_d_ev  = w_ud_ev[1] && !w_l_any && !w_rise[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_blk <= '0;
        else if (w_chg)
            r_blk <= r_deb[3:2];
        else
            r_blk <= r_blk & r_deb[3:2];
    end

    logic       r_sel, r_set, r_up, r_dn, r_rs, r_clr;
    logic [1:0] r_fld;
    logic       w_sel_n, w_set_n, w_up_n, w_dn_n, w_rs_n, w_clr_n;
    logic [1:0] w_fld_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_WATCH;
            r_sel   <= 1'b0;
            r_set   <= 1'b0;
            r_fld   <= 2'd0;
            r_up    <= 1'b0;
            r_dn    <= 1'b0;
            r_rs    <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel_n;
            r_set   <= w_set_n;
            r_fld   <= w_fld_n;
            r_up    <= w_up_n;
            r_dn    <= w_dn_n;
            r_rs    <= w_rs_n;
            r_clr   <= w_clr_n;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_WATCH: begin
                if (w_l_long)       w_next = S_SW;
                else if (w_l_short) w_next = S_HOUR;
            end
            S_SW: begin
                if (w_l_long) w_next = S_WATCH;
            end
            S_HOUR: begin
                if (w_l_short)   w_next = S_MIN;
                else if (w_r_ev) w_next = S_WATCH;
            end
            S_MIN: begin
                if (w_l_short)   w_next = S_SEC;
                else if (w_r_ev) w_next = S_WATCH;
            end
            S_SEC: begin
                if (w_l_short || w_r_ev) w_next = S_WATCH;
            end
            default: w_next = S_WATCH;
        endcase
    end

    always_comb begin
        w_sel_n = 1'b0;
        w_set_n = 1'b0;
        w_fld_n = 2'd0;
        unique case (w_next)
            S_SW:   w_sel_n = 1'b1;
            S_HOUR: begin w_set_n = 1'b1; w_fld_n = 2'd1; end
            S_MIN:  begin w_set_n = 1'b1; w_fld_n = 2'd2; end
            S_SEC:  begin w_set_n = 1'b1; w_fld_n = 2'd3; end
            default: ;
        endcase
        w_clr_n = (r_state == S_SW) && w_l_short;
        w_rs_n  = (r_state == S_SW) && w_r_ev;
        w_up_n  = w_in_set && w_u_ev;
        w_dn_n  = w_in_set && w_d_ev;
    end

    assign sel        = r_sel;
    assign set_mode   = r_set;
    assign wt_field   = r_fld;
    assign wt_up      = r_up;
    assign wt_down    = r_dn;
    assign sw_runstop = r_rs;
    assign sw_clear   = r_clr;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// tb_btn_mode_ctrl: directed vector table plus hand-timed sequences
// for btn_mode_ctrl with DB_CYC=4, LONG_CYC=40, RPT_CYC=10.
module tb_btn_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0;
    logic       sel, set_mode, wt_up, wt_down, sw_runstop, sw_clear;
    logic [1:0] wt_field;

    btn_mode_ctrl #(
        .DB_CYC  (4),
        .LONG_CYC(40),
        .RPT_CYC (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btnL      (btnL),
        .btnR      (btnR),
        .btnU      (btnU),
        .btnD      (btnD),
        .sel       (sel),
        .set_mode  (set_mode),
        .wt_field  (wt_field),
        .wt_up     (wt_up),
        .wt_down   (wt_down),
        .sw_runstop(sw_runstop),
        .sw_clear  (sw_clear)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_up = 0, n_dn = 0, n_rs = 0, n_clr = 0;
    int up_q[$];
    int rs_last = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("one_pulse",
                32'($countones({wt_up, wt_down, sw_runstop, sw_clear}) <= 1),
                32'd1);
            if (wt_up) begin n_up++; up_q.push_back(cyc); end
            if (wt_down) n_dn++;
            if (sw_runstop) begin n_rs++; rs_last = cyc; end
            if (sw_clear) n_clr++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] m);
        {btnD, btnU, btnR, btnL} = m;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        drive(m);
        tick(hold);
        drive(4'b0000);
        tick(12);
    endtask

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic       e_sel;
        logic       e_set;
        logic [1:0] e_fld;
        int         e_up, e_dn, e_rs, e_clr;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int s, c0, base;
        int u0, d0, r0, k0;

        tbl[0]  = '{4'b0001, 10, 1'b0, 1'b1, 2'd1, 0, 0, 0, 0};
        tbl[1]  = '{4'b0100, 10, 1'b0, 1'b1, 2'd1, 1, 0, 0, 0};
        tbl[2]  = '{4'b1000, 10, 1'b0, 1'b1, 2'd1, 0, 1, 0, 0};
        tbl[3]  = '{4'b1100, 10, 1'b0, 1'b1, 2'd1, 0, 0, 0, 0};
        tbl[4]  = '{4'b0001, 10, 1'b0, 1'b1, 2'd2, 0, 0, 0, 0};
        tbl[5]  = '{4'b0001, 60, 1'b0, 1'b1, 2'd2, 0, 0, 0, 0};
        tbl[6]  = '{4'b0001, 10, 1'b0, 1'b1, 2'd3, 0, 0, 0, 0};
        tbl[7]  = '{4'b0010, 10, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0};
        tbl[8]  = '{4'b0100, 10, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0};
        tbl[9]  = '{4'b0010, 10, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0};
        tbl[10] = '{4'b0001, 60, 1'b1, 1'b0, 2'd0, 0, 0, 0, 0};
        tbl[11] = '{4'b0010, 10, 1'b1, 1'b0, 2'd0, 0, 0, 1, 0};
        tbl[12] = '{4'b0001, 10, 1'b1, 1'b0, 2'd0, 0, 0, 0, 1};
        tbl[13] = '{4'b0100, 10, 1'b1, 1'b0, 2'd0, 0, 0, 0, 0};
        tbl[14] = '{4'b0001, 60, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0};
        tbl[15] = '{4'b0001, 10, 1'b0, 1'b1, 2'd1, 0, 0, 0, 0};
        tbl[16] = '{4'b0001, 10, 1'b0, 1'b1, 2'd2, 0, 0, 0, 0};
        tbl[17] = '{4'b0001, 10, 1'b0, 1'b1, 2'd3, 0, 0, 0, 0};
        tbl[18] = '{4'b0001, 10, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0};

        // reset state
        tick(3);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_set", 32'(set_mode), 32'd0);
        chk("rst_fld", 32'(wt_field), 32'd0);
        chk("rst_up", 32'(wt_up), 32'd0);
        chk("rst_rs", 32'(sw_runstop), 32'd0);
        rst = 1'b1;
        tick(2);

        // long L toggle timing: sel rises 47 cycles after the press
        s = cyc;
        btnL = 1'b1;
        tick(46);
        chk("long_early", 32'(sel), 32'd0);
        tick(1);
        chk("long_sel", 32'(sel), 32'd1);
        c0 = n_clr;
        tick(13);
        btnL = 1'b0;
        tick(12);
        chk("long_noclr", 32'(n_clr - c0), 32'd0);
        chk("long_stay", 32'(sel), 32'd1);

        // bounce rejection on R in STOPWATCH
        r0 = n_rs;
        for (int i = 0; i < 10; i++) begin
            btnR = (i % 2 == 0);
            tick(2);
        end
        s = cyc;
        btnR = 1'b1;
        tick(10);
        btnR = 1'b0;
        tick(12);
        chk("bounce_cnt", 32'(n_rs - r0), 32'd1);
        chk("bounce_lat", 32'(rs_last - s), 32'd7);

        press(4'b0001, 60);
        chk("back_watch", 32'(sel), 32'd0);

        // vector table
        for (int i = 0; i < 19; i++) begin
            u0 = n_up; d0 = n_dn; r0 = n_rs; k0 = n_clr;
            press(tbl[i].btn, tbl[i].hold);
            chk($sformatf("row%0d_sel", i), 32'(sel), 32'(tbl[i].e_sel));
            chk($sformatf("row%0d_set", i), 32'(set_mode),
                32'(tbl[i].e_set));
            chk($sformatf("row%0d_fld", i), 32'(wt_field),
                32'(tbl[i].e_fld));
            chk($sformatf("row%0d_up", i), 32'(n_up - u0), 32'(tbl[i].e_up));
            chk($sformatf("row%0d_dn", i), 32'(n_dn - d0), 32'(tbl[i].e_dn));
            chk($sformatf("row%0d_rs", i), 32'(n_rs - r0), 32'(tbl[i].e_rs));
            chk($sformatf("row%0d_clr", i), 32'(n_clr - k0),
                32'(tbl[i].e_clr));
        end

        // auto-repeat in SET_MIN
        press(4'b0001, 10);
        press(4'b0001, 10);
        chk("rpt_min", 32'(wt_field), 32'd2);
        base = up_q.size();
        s = cyc;
        btnU = 1'b1;
        tick(68);
        btnU = 1'b0;
        tick(12);
`ifdef AUTO_REPEAT_EN
        chk("rpt_count", 32'(up_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            int off [4] = '{7, 47, 57, 67};
            if (base + i < up_q.size())
                chk($sformatf("rpt_at%0d", i), 32'(up_q[base+i] - s),
                    32'(off[i]));
        end
`else
        chk("rpt_count", 32'(up_q.size() - base), 32'd1);
        if (base < up_q.size())
            chk("rpt_at0", 32'(up_q[base] - s), 32'd7);
`endif

        // short L release coincident with R press in SET_HOUR
        press(4'b0010, 10);
        press(4'b0001, 10);
        chk("cf_hour", 32'(wt_field), 32'd1);
        btnL = 1'b1;
        tick(10);
        btnL = 1'b0;
        btnR = 1'b1;
        tick(10);
        btnR = 1'b0;
        tick(12);
        chk("cf_fld", 32'(wt_field), 32'd2);
        chk("cf_set", 32'(set_mode), 32'd1);

        // reset while U held in SET_SEC
        press(4'b0001, 10);
        chk("mr_sec", 32'(wt_field), 32'd3);
        btnU = 1'b1;
        tick(12);
        rst = 1'b0;
        #2;
        chk("mr_fld", 32'(wt_field), 32'd0);
        chk("mr_set", 32'(set_mode), 32'd0);
        chk("mr_up", 32'(wt_up), 32'd0);
        tick(3);
        rst = 1'b1;
        u0 = n_up;
        tick(30);
        chk("mr_noup", 32'(n_up - u0), 32'd0);
        chk("mr_watch", 32'(wt_field), 32'd0);
        btnU = 1'b0;
        tick(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
